// File: rtl/mem_stage.sv
// Memory stage: holds one EX instruction, aligns/extends SRAM load data and hands it to WB.
// Optional macro MS_FWD_EN adds the ms_fwd_bus forwarding/block port.
module mem_stage (
  input  logic         clk,
  input  logic         reset,
  // Handshake: a transfer occurs on a clock edge where the producer's valid and the
  // consumer's allowin are both high; a flush on that edge discards the transfer.
  input  logic         es2ms_valid,
  output logic         ms_allowin,
  input  logic [156:0] es2ms_bus,
  input  logic         ws_allowin,
  output logic         ms2ws_valid,
  output logic [151:0] ms2ws_bus,
  input  logic [31:0]  data_sram_rdata,
  input  logic         wb_ex,
  input  logic         ertn_flush,
  output logic         ms_ex
`ifdef MS_FWD_EN
  ,
  output logic [38:0]  ms_fwd_bus
`endif
);

  localparam logic [4:0] LD_B  = 5'b10000;
  localparam logic [4:0] LD_H  = 5'b01000;
  localparam logic [4:0] LD_W  = 5'b00100;
  localparam logic [4:0] LD_BU = 5'b00010;
  localparam logic [4:0] LD_HU = 5'b00001;

  logic        ms_ready_go;
  logic        flush;
  logic        capture;

  logic        ms_valid_q;
  logic        ms_valid_d;

  logic [31:0] pc_q;
  logic        gr_we_q;
  logic [4:0]  dest_q;
  logic [31:0] alu_result_q;
  logic [4:0]  load_op_q;
  logic [81:0] except_zip_q;

  logic        hold_valid_q;
  logic        hold_valid_d;
  logic [31:0] hold_data_q;
  logic [31:0] hold_data_d;

  logic [31:0] rdata_sel;
  logic [7:0]  byte_sel;
  logic [15:0] half_sel;
  logic [31:0] load_data;
  logic [31:0] final_result;

  assign ms_ready_go = 1'b1;
  assign flush       = wb_ex | ertn_flush;
  assign ms_allowin  = !ms_valid_q || (ms_ready_go && ws_allowin);
  assign ms2ws_valid = ms_valid_q & ms_ready_go;
  assign capture     = es2ms_valid & ms_allowin;

  always_comb begin
    ms_valid_d = ms_valid_q;
    if (flush) begin
      ms_valid_d = 1'b0;
    end else if (ms_allowin) begin
      ms_valid_d = es2ms_valid;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ms_valid_q <= 1'b0;
    end else begin
      ms_valid_q <= ms_valid_d;
    end
  end

  // Payload is qualified by ms_valid_q everywhere, so it carries no reset.
  always_ff @(posedge clk) begin
    if (capture) begin
      pc_q         <= es2ms_bus[156:125];
      gr_we_q      <= es2ms_bus[124];
      dest_q       <= es2ms_bus[123:119];
      alu_result_q <= es2ms_bus[118:87];
      load_op_q    <= es2ms_bus[86:82];
      except_zip_q <= es2ms_bus[81:0];
    end
  end

  // The SRAM word is only valid in the first cycle; a stall freezes it here until departure.
  always_comb begin
    hold_valid_d = hold_valid_q;
    hold_data_d  = hold_data_q;
    if (flush || ms_allowin) begin
      hold_valid_d = 1'b0;
    end else if (!hold_valid_q) begin
      hold_valid_d = 1'b1;
      hold_data_d  = data_sram_rdata;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      hold_valid_q <= 1'b0;
    end else begin
      hold_valid_q <= hold_valid_d;
    end
  end

  always_ff @(posedge clk) begin
    hold_data_q <= hold_data_d;
  end

  assign rdata_sel = hold_valid_q ? hold_data_q : data_sram_rdata;

  always_comb begin
    byte_sel = rdata_sel[7:0];
    case (alu_result_q[1:0])
      2'd0:    byte_sel = rdata_sel[7:0];
      2'd1:    byte_sel = rdata_sel[15:8];
      2'd2:    byte_sel = rdata_sel[23:16];
      default: byte_sel = rdata_sel[31:24];
    endcase
  end

  assign half_sel = alu_result_q[1] ? rdata_sel[31:16] : rdata_sel[15:0];

  always_comb begin
    load_data = 32'h0;
    case (load_op_q)
      LD_B:    load_data = {{24{byte_sel[7]}}, byte_sel};
      LD_H:    load_data = {{16{half_sel[15]}}, half_sel};
      LD_W:    load_data = rdata_sel;
      LD_BU:   load_data = {24'h0, byte_sel};
      LD_HU:   load_data = {16'h0, half_sel};
      default: load_data = 32'h0;
    endcase
  end

  assign final_result = (load_op_q != 5'd0) ? load_data : alu_result_q;

  assign ms2ws_bus = ms_valid_q ? {pc_q, gr_we_q, dest_q, final_result, except_zip_q}
                                : 152'h0;

  assign ms_ex = ms_valid_q & (except_zip_q[3] | except_zip_q[2]);

`ifdef MS_FWD_EN
  logic        fwd_we;
  logic [4:0]  fwd_dest;
  logic [31:0] fwd_data;
  logic        ms_block;

  // A CSR read result is produced in WB, so consumers must stall rather than forward.
  assign fwd_we     = ms_valid_q & gr_we_q & (dest_q != 5'd0);
  assign fwd_dest   = ms_valid_q ? dest_q : 5'd0;
  assign fwd_data   = ms_valid_q ? final_result : 32'h0;
  assign ms_block   = ms_valid_q & except_zip_q[1];
  assign ms_fwd_bus = {fwd_we, fwd_dest, fwd_data, ms_block};
`endif

endmodule

// File: doc/mem_stage.md
MEM_STAGE -- requirements
Module: mem_stage

Interface
REQ-001 SHALL have ports: clk  in  1  clock; reset  in  1  synchronous, active-high reset.
REQ-002 SHALL have: es2ms_valid  in  1  EX payload valid; ms_allowin  out  1  MEM can accept.
REQ-003 SHALL have: es2ms_bus  in  157  {pc[31:0], gr_we, dest[4:0], alu_result[31:0], load_op[4:0], except_zip[81:0]}, where load_op is one-hot {ld_b, ld_h, ld_w, ld_bu, ld_hu}.
REQ-004 SHALL have: ws_allowin  in  1  WB can accept; ms2ws_valid  out  1  MEM payload valid.
REQ-005 SHALL have: ms2ws_bus  out  152  {pc, gr_we, dest, final_result[31:0], except_zip[81:0]}.
REQ-006 SHALL have: data_sram_rdata  in  32  synchronous SRAM read data, valid the cycle after EX issued the request.
REQ-007 SHALL have: wb_ex, ertn_flush  in  1 each  WB flush requests.
REQ-008 SHALL have: ms_ex  out  1  MEM holds a valid exception/ertn, used by EX to cancel stores.
REQ-009 SHALL have: ms_fwd_bus  out  39  {fwd_we, fwd_dest[4:0], fwd_data[31:0], ms_block}; present only per REQ-024.

Function
REQ-010 ms_ready_go SHALL be 1; ms_allowin SHALL equal !ms_valid | (ms_ready_go & ws_allowin); ms2ws_valid SHALL equal ms_valid & ms_ready_go.
REQ-011 On a clock edge with wb_ex | ertn_flush, ms_valid SHALL become 0 regardless of es2ms_valid (flush wins over accept).
REQ-012 Otherwise, when ms_allowin, ms_valid SHALL load es2ms_valid; when not ms_allowin, ms_valid SHALL hold.
REQ-013 Payload registers SHALL capture es2ms_bus only when es2ms_valid & ms_allowin, and hold otherwise.
REQ-014 Load data: rdata_sel SHALL be data_sram_rdata in the first cycle after capture; if MEM stalls (!ws_allowin), the SRAM word SHALL be latched in a holding register at the end of that first cycle, and the holding register SHALL drive rdata_sel until the instruction leaves.
REQ-015 Byte select SHALL use alu_result[1:0]; halfword select SHALL use alu_result[1] (0 selects bits 15:0, 1 selects bits 31:16).
REQ-016 ld_b/ld_h SHALL sign-extend; ld_bu/ld_hu SHALL zero-extend; ld_w SHALL pass the word unchanged.
REQ-017 final_result SHALL be the extended load data when load_op != 0, otherwise alu_result.
REQ-018 except_zip SHALL pass through unchanged; bit 3 = ex, bit 2 = ertn, bit 1 = csr_re.
REQ-019 ms_ex SHALL equal ms_valid & (except_zip[3] | except_zip[2]).
REQ-020 ms_valid SHALL become 1 only through REQ-012; a flush in the same cycle as an EX handoff SHALL discard that handoff.

Reset
REQ-021 With reset high at a clock edge, ms_valid SHALL be 0, the holding-register valid flag SHALL be 0, and ms2ws_valid, ms_ex, and fwd_we SHALL be 0 in the following cycle.
REQ-022 Payload registers SHALL NOT require reset; no output SHALL depend on them while ms_valid = 0.
REQ-023 Reset SHALL take priority over flush and accept.

Configuration
REQ-024 Macro MS_FWD_EN defined: ms_fwd_bus SHALL be present, with fwd_we = ms_valid & gr_we & (dest != 0), fwd_dest = dest, fwd_data = final_result, and ms_block = ms_valid & except_zip[1] (CSR read not yet resolvable). Macro undefined: the port SHALL be absent and no forwarding logic SHALL be built.

Verification
REQ-025 Scenario 1: ld.b, alu_result = 0x1003, rdata = 0x80_12_34_56, ws_allowin = 1 -> next cycle ms2ws_valid = 1, final_result = 0xFFFFFF80.
REQ-026 Scenario 2: ld.hu, alu_result = 0x2002, rdata = 0xBEEF1234 -> final_result = 0x0000BEEF; ld.h with the same inputs -> 0xFFFFBEEF.
REQ-027 Scenario 3: ld.w is accepted, ws_allowin = 0 for 3 cycles, and rdata changes to 0xDEADDEAD after cycle 1 -> on release, final_result = the original word; ms_allowin = 0 during the stall.
REQ-028 Scenario 4: wb_ex = 1 in the same cycle as es2ms_valid = 1 and ms_allowin = 1 -> next cycle ms_valid = 0 and ms2ws_valid = 0.
REQ-029 Scenario 5: MEM holds except_zip[3] = 1 with ms_valid = 1 -> ms_ex = 1; after the WB flush edge -> ms_ex = 0.
REQ-030 Scenario 6 (MS_FWD_EN defined): add with dest = 5, result = 0x55 -> fwd_we = 1, fwd_dest = 5, fwd_data = 0x55; with dest = 0 -> fwd_we = 0; csrrd -> ms_block = 1.
